input_fifo_buffer: RTL and testbench
====================================

// Module: input_fifo_buffer
// PURPOSE
//  Per-port packet FIFO between the inter-router link and the input port controller.
//  Write side takes packets from the upstream link with valid/full flow control.
//  Read side serves the controller's req/gnt/empty handshake. A one-cycle req pulse
//  pops the head packet into a held output register and returns a one-cycle gnt.
//  One instance per router input direction (E, N, W, S, Local).
// PARAMETERS
//  packetwidth  55  packet width in bits; must equal the input controller's packetwidth
//  DEPTH        4   number of packet entries, >=2; need not be a power of two
//  ADDRW        2   pointer width, ceil(log2(DEPTH))
//  AFULL_LVL    3   occupancy at or above which almost_full = 1
// PORTS
//  clk          in   1              rising-edge clock
//  reset        in   1              asynchronous, active-high reset
//  valid_in     in   1              upstream presents a packet on data_in this cycle
//  data_in      in   packetwidth    packet from the link
//  full         out  1              count == DEPTH (combinational from count)
//  almost_full  out  1              count >= AFULL_LVL (combinational)
//  req          in   1              pop request from the input port controller
//  gnt          out  1              registered one-cycle grant; PacketOut is valid from this cycle
//  empty        out  1              count == 0 (combinational)
//  PacketOut    out  packetwidth    registered head packet; held until the next pop
//  count        out  ADDRW+1        current occupancy, 0..DEPTH
//  overflow     out  1              sticky; set when valid_in && full; cleared only by reset
// BEHAVIOUR
//  Reset (async, while reset = 1):
//   - wr_ptr = rd_ptr = count = 0; gnt = 0; PacketOut = 0; overflow = 0.
//   - Resulting outputs: empty = 1, full = 0.
//   - Storage array is not reset.
//  push = valid_in && !full.
//   - A write while full is dropped and sets overflow. There is no write-through on a full FIFO.
//  pop = req && !empty && !gnt, sampled on the clock edge. On a pop:
//   - PacketOut <= mem[rd_ptr]; gnt <= 1; rd_ptr advances.
//  gnt is high for exactly one cycle after each pop, then returns to 0.
//   - req seen while gnt = 1 is ignored, so at most one pop per two cycles.
//   - A held-high req therefore pops every other cycle.
//  req while empty is ignored: no gnt, no pointer change, PacketOut unchanged.
//  Latency:
//   - req sampled at edge N -> gnt = 1 and new PacketOut after edge N.
//   - The controller captures PacketOut at edge N+2; PacketOut is stable through then.
//  Pointer wrap: a pointer at DEPTH-1 goes to 0 on advance. No power-of-two assumption.
//  Count update per edge:
//   - push only: +1
//   - pop only: -1
//   - push and pop together: unchanged
//   - neither: unchanged
//  Simultaneous push and pop at count == 0: no pop (empty wins); push lands and count = 1.
//  Simultaneous push and pop at count == DEPTH: push is rejected (full is evaluated before the pop).
//   - count becomes DEPTH-1 and overflow sets.
//  empty and full update in the same cycle count changes.
//   - The controller observes empty = 1 after popping the last entry before it re-requests.
//  Ordering: strict FIFO; packets leave in arrival order.
//  Reset mid-operation:
//   - All state clears immediately, including any pending gnt.
//   - In-flight packets are discarded.
// TESTING
//  T1 reset: hold reset=1 for 3 cycles -> empty=1, full=0, gnt=0, count=0, PacketOut=0, overflow=0.
//  T2 fill/overflow: push 0x11,0x22,0x33,0x44 -> full=1, count=4; push 0x55 -> dropped, overflow=1, count=4.
//  T3 order: after T2, pulse req 1 cycle four times, 2 cycles apart
//   -> gnt pulses with PacketOut 0x11, 0x22, 0x33, 0x44 in order; empty=1 after the 4th.
//  T4 concurrent: at count=2, valid_in and req on the same edge -> count stays 2, gnt=1, head advances.
//  T5 wrap: stream 10 packets through DEPTH=4 with interleaved pops -> output equals input order, no loss.
//  T6 edge cases: req with empty=1 -> no gnt, PacketOut unchanged.
//   - Assert reset between a pop edge and the gnt cycle -> gnt=0 and count=0 immediately.

Source files
------------

// File: rtl/input_fifo_buffer_if.sv
//------------------------------------------------------------------------------
// Interface     : input_fifo_buffer_if
// Description   : Link-side write handshake and controller-side req/gnt read
//                 handshake for one router input FIFO.
// Revision      : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface input_fifo_buffer_if #(
  parameter int packetwidth = 55,
  parameter int ADDRW       = 2
);
  logic                   valid_in;
  logic [packetwidth-1:0] data_in;
  logic                   full;
  logic                   almost_full;
  logic                   req;
  logic                   gnt;
  logic                   empty;
  logic [packetwidth-1:0] PacketOut;
  logic [ADDRW:0]         count;
  logic                   overflow;

  // Upstream link plus input port controller side
  modport master (
    output valid_in, data_in, req,
    input  full, almost_full, gnt, empty, PacketOut, count, overflow
  );

  // FIFO side
  modport slave (
    input  valid_in, data_in, req,
    output full, almost_full, gnt, empty, PacketOut, count, overflow
  );
endinterface

`default_nettype wire

// File: rtl/input_fifo_buffer.sv
//------------------------------------------------------------------------------
// Module        : input_fifo_buffer
// Description   : Per-port packet FIFO between the inter-router link and the
//                 input port controller. valid/full on the write side, one-pop
//                 per req pulse with a registered one-cycle gnt on the read side.
// Revision      : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module input_fifo_buffer #(
  parameter int packetwidth = 55,
  parameter int DEPTH       = 4,
  parameter int ADDRW       = 2,
  parameter int AFULL_LVL   = 3
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input_fifo_buffer_if.slave bus
);

  localparam logic [ADDRW:0]   DEPTH_CNT = (ADDRW+1)'(DEPTH);
  localparam logic [ADDRW:0]   AFULL_CNT = (ADDRW+1)'(AFULL_LVL);
  localparam logic [ADDRW:0]   CNT_ONE   = (ADDRW+1)'(1);
  localparam logic [ADDRW-1:0] LAST_PTR  = ADDRW'(DEPTH-1);

  logic [packetwidth-1:0] mem [DEPTH];
  logic [ADDRW-1:0]       wr_ptr;
  logic [ADDRW-1:0]       rd_ptr;
  logic [ADDRW:0]         count;
  logic                   gnt;
  logic                   overflow;
  logic [packetwidth-1:0] packet_out;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two
  function automatic logic [ADDRW-1:0] next_ptr(input logic [ADDRW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  // full is judged on the pre-edge count, so a pop cannot make room for a
  // push arriving on the same edge; gnt blocks back-to-back pops
  assign push  = bus.valid_in && !full;
  assign pop   = bus.req && !empty && !gnt;

  // Packet storage; deliberately not reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // Pointers, occupancy, grant, output register and sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      gnt        <= 1'b0;
      packet_out <= '0;
      overflow   <= 1'b0;
    end else begin
      gnt <= pop;
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr     <= next_ptr(rd_ptr);
        packet_out <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (bus.valid_in && full) begin
        overflow <= 1'b1;
      end
    end
  end

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almost_full = (count >= AFULL_CNT);
  assign bus.gnt         = gnt;
  assign bus.PacketOut   = packet_out;
  assign bus.count       = count;
  assign bus.overflow    = overflow;

endmodule

`default_nettype wire

// File: tb/tb_input_fifo_buffer.sv
//------------------------------------------------------------------------------
// Module        : tb_input_fifo_buffer
// Description   : Directed self-checking bench for input_fifo_buffer.
// Revision      : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_input_fifo_buffer;

  localparam int PW = 55;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  input_fifo_buffer_if #(.packetwidth(PW), .ADDRW(2)) bus ();

  input_fifo_buffer #(
    .packetwidth(PW),
    .DEPTH      (4),
    .ADDRW      (2),
    .AFULL_LVL  (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference queue for the streaming phase
  logic [PW-1:0] q[$];
  logic          mgnt;
  logic [PW-1:0] last_out;

  task automatic model_cycle(input logic v, input logic [PW-1:0] d, input logic r);
    logic          mpush;
    logic          mpop;
    logic [PW-1:0] expv;
    expv         = '0;
    bus.valid_in = v;
    bus.data_in  = d;
    bus.req      = r;
    mpush = v && (q.size() < 4);
    mpop  = r && (q.size() > 0) && !mgnt;
    if (mpop) expv = q.pop_front();
    if (mpush) q.push_back(d);
    mgnt = mpop;
    tick();
    check("stream_gnt", 64'(bus.gnt), 64'(mgnt));
    check("stream_count", 64'(bus.count), 64'(q.size()));
    if (mpop) begin
      check("stream_data", 64'(bus.PacketOut), 64'(expv));
      last_out = expv;
    end
  endtask

  initial begin
    logic [PW-1:0] fill_d [4];
    fill_d = '{55'h11, 55'h22, 55'h33, 55'h44};

    // T1 reset
    reset        = 1'b1;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    bus.req      = 1'b0;
    repeat (3) tick();
    check("rst_empty", 64'(bus.empty), 64'd1);
    check("rst_full", 64'(bus.full), 64'd0);
    check("rst_gnt", 64'(bus.gnt), 64'd0);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_pkt", 64'(bus.PacketOut), 64'd0);
    check("rst_ovf", 64'(bus.overflow), 64'd0);
    reset = 1'b0;
    tick();

    // T2 fill then overflow
    for (int k = 0; k < 4; k++) begin
      bus.valid_in = 1'b1;
      bus.data_in  = fill_d[k];
      tick();
      check("fill_count", 64'(bus.count), 64'(k + 1));
      check("fill_afull", 64'(bus.almost_full), 64'((k + 1) >= 3));
      check("fill_full", 64'(bus.full), 64'(k == 3));
    end
    bus.data_in = 55'h55;
    tick();
    bus.valid_in = 1'b0;
    check("ovf_flag", 64'(bus.overflow), 64'd1);
    check("ovf_count", 64'(bus.count), 64'd4);

    // T3 ordered pops, one req pulse every two cycles
    for (int k = 0; k < 4; k++) begin
      bus.req = 1'b1;
      tick();
      bus.req = 1'b0;
      check("pop_gnt", 64'(bus.gnt), 64'd1);
      check("pop_data", 64'(bus.PacketOut), 64'(fill_d[k]));
      tick();
      check("pop_gnt_low", 64'(bus.gnt), 64'd0);
      check("pop_hold", 64'(bus.PacketOut), 64'(fill_d[k]));
    end
    check("drain_empty", 64'(bus.empty), 64'd1);
    check("drain_count", 64'(bus.count), 64'd0);

    // T4 simultaneous push and pop at count 2
    bus.valid_in = 1'b1;
    bus.data_in  = 55'hA1;
    tick();
    bus.data_in  = 55'hA2;
    tick();
    check("c2_count", 64'(bus.count), 64'd2);
    bus.data_in  = 55'hA3;
    bus.req      = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    bus.req      = 1'b0;
    check("conc_count", 64'(bus.count), 64'd2);
    check("conc_gnt", 64'(bus.gnt), 64'd1);
    check("conc_data", 64'(bus.PacketOut), 64'hA1);
    tick();
    check("conc_gnt_low", 64'(bus.gnt), 64'd0);

    // T5 stream 10 packets through with req held high, then drain
    q.delete();
    q.push_back(55'hA2);
    q.push_back(55'hA3);
    mgnt     = 1'b0;
    last_out = 55'hA1;
    for (int k = 0; k < 20; k++) begin
      model_cycle((k % 2) == 0, PW'(55'hB0 + (k / 2)), 1'b1);
    end
    for (int k = 0; k < 16; k++) begin
      model_cycle(1'b0, '0, 1'b1);
    end
    bus.req = 1'b0;
    check("stream_last", 64'(last_out), 64'h0B9);
    check("stream_empty", 64'(bus.empty), 64'd1);

    // T6 req while empty is ignored
    tick();
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    check("empty_req_gnt", 64'(bus.gnt), 64'd0);
    check("empty_req_pkt", 64'(bus.PacketOut), 64'h0B9);
    check("empty_req_count", 64'(bus.count), 64'd0);

    // T6 reset lands between the pop edge and the gnt cycle
    bus.valid_in = 1'b1;
    bus.data_in  = 55'hC1;
    tick();
    bus.valid_in = 1'b0;
    bus.req      = 1'b1;
    tick();
    bus.req      = 1'b0;
    check("pre_rst_gnt", 64'(bus.gnt), 64'd1);
    check("pre_rst_pkt", 64'(bus.PacketOut), 64'hC1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_gnt", 64'(bus.gnt), 64'd0);
    check("mid_rst_count", 64'(bus.count), 64'd0);
    check("mid_rst_pkt", 64'(bus.PacketOut), 64'd0);
    check("mid_rst_ovf", 64'(bus.overflow), 64'd0);
    check("mid_rst_empty", 64'(bus.empty), 64'd1);
    tick();
    reset = 1'b0;
    tick();

    // Push and pop together while empty: push lands, no pop
    bus.valid_in = 1'b1;
    bus.data_in  = 55'hE0;
    bus.req      = 1'b1;
    tick();
    bus.req = 1'b0;
    check("e_pp_count", 64'(bus.count), 64'd1);
    check("e_pp_gnt", 64'(bus.gnt), 64'd0);
    check("e_pp_empty", 64'(bus.empty), 64'd0);
    for (int k = 1; k < 4; k++) begin
      bus.data_in = PW'(55'hD0 + k);
      tick();
    end
    check("f_count", 64'(bus.count), 64'd4);

    // Push and pop together while full: push rejected, pop proceeds
    bus.data_in = 55'hD4;
    bus.req     = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    bus.req      = 1'b0;
    check("f_pp_count", 64'(bus.count), 64'd3);
    check("f_pp_ovf", 64'(bus.overflow), 64'd1);
    check("f_pp_gnt", 64'(bus.gnt), 64'd1);
    check("f_pp_data", 64'(bus.PacketOut), 64'hE0);
    check("f_pp_full", 64'(bus.full), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
